// File: rtl/adc_capture_ctrl.sv
// Writes the 120-bit merged ADC stream into a circular trace BRAM and freezes one
// pre/post-trigger event for readout, handing it over with a READY/ACK handshake.
module adc_capture_ctrl #(
  parameter int ADDR_WIDTH = 11,
  parameter int PRE_TRIG   = 512,
  parameter int POST_TRIG  = 1535
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  ENABLE,
  input  logic                  TRIGGER,
  input  logic                  ACK,
  input  logic [119:0]          ADC_IN,
  output logic                  WR_EN,
  output logic [ADDR_WIDTH-1:0] WR_ADDR,
  output logic [119:0]          WR_DATA,
  output logic                  READY,
  output logic [ADDR_WIDTH-1:0] START_ADDR,
  output logic [ADDR_WIDTH-1:0] TRIG_ADDR,
  output logic                  BUSY,
  output logic [15:0]           MISSED
);

  localparam int CW = ADDR_WIDTH + 1;
  localparam logic [CW-1:0] PRE_N  = CW'(PRE_TRIG);
  localparam logic [CW-1:0] POST_N = CW'(POST_TRIG);

  if (PRE_TRIG + 1 + POST_TRIG > (1 << ADDR_WIDTH)) begin : g_size_check
    $error("adc_capture_ctrl: event does not fit in the buffer");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_ARMED,
    S_POST,
    S_HOLD
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic                  r_wr_en;
  logic [ADDR_WIDTH-1:0] r_wr_addr;
  logic [119:0]          r_wr_data;
  logic [ADDR_WIDTH-1:0] r_start_addr;
  logic [ADDR_WIDTH-1:0] r_trig_addr;
  logic [15:0]           r_missed;
  logic [CW-1:0]         r_pre_cnt;
  logic [CW-1:0]         r_post_cnt;
  logic                  w_wr_en_nxt;
  logic                  w_trig_acc;
  logic                  w_miss;
  logic [ADDR_WIDTH-1:0] w_addr_nxt;

  // Address of the sample captured at this edge: one past the last written word.
  assign w_addr_nxt = r_wr_addr + {{(ADDR_WIDTH-1){1'b0}}, r_wr_en};

  always_comb begin
    w_next     = r_state;
    w_trig_acc = 1'b0;
    w_miss     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (ENABLE) w_next = (PRE_TRIG == 0) ? S_ARMED : S_FILL;
      end
      S_FILL: begin
        w_miss = TRIGGER;
        if (!ENABLE)                           w_next = S_IDLE;
        else if ((r_pre_cnt + CW'(1)) >= PRE_N) w_next = S_ARMED;
      end
      S_ARMED: begin
        // A trigger coinciding with ENABLE falling still completes the event.
        if (TRIGGER) begin
          w_trig_acc = 1'b1;
          w_next     = S_POST;
        end else if (!ENABLE) begin
          w_next = S_IDLE;
        end
      end
      S_POST: begin
        w_miss = TRIGGER;
        if (r_post_cnt >= POST_N) w_next = S_HOLD;
      end
      S_HOLD: begin
        w_miss = TRIGGER;
        if (ACK) begin
          if (!ENABLE)            w_next = S_IDLE;
          else if (PRE_TRIG == 0) w_next = S_ARMED;
          else                    w_next = S_FILL;
        end
      end
      default: w_next = S_IDLE;
    endcase
    w_wr_en_nxt = (w_next == S_FILL) || (w_next == S_ARMED) || (w_next == S_POST);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state      <= S_IDLE;
      r_wr_en      <= 1'b0;
      r_wr_addr    <= '0;
      r_wr_data    <= '0;
      r_start_addr <= '0;
      r_trig_addr  <= '0;
      r_missed     <= '0;
      r_pre_cnt    <= '0;
      r_post_cnt   <= '0;
    end else begin
      r_state    <= w_next;
      r_wr_en    <= w_wr_en_nxt;
      r_wr_addr  <= w_addr_nxt;
      r_wr_data  <= ADC_IN;
      r_pre_cnt  <= (r_state == S_FILL) ? r_pre_cnt + CW'(1) : '0;
      r_post_cnt <= (r_state == S_POST) ? r_post_cnt + CW'(1) : '0;
      if (w_trig_acc) begin
        r_trig_addr  <= w_addr_nxt;
        r_start_addr <= w_addr_nxt - ADDR_WIDTH'(PRE_TRIG);
      end
      if (w_miss && (r_missed != 16'hFFFF)) r_missed <= r_missed + 16'd1;
    end
  end

  assign WR_EN      = r_wr_en;
  assign WR_ADDR    = r_wr_addr;
  assign WR_DATA    = r_wr_data;
  assign READY      = (r_state == S_HOLD);
  assign BUSY       = (r_state != S_IDLE);
  assign START_ADDR = r_start_addr;
  assign TRIG_ADDR  = r_trig_addr;
  assign MISSED     = r_missed;

endmodule
